// File: rtl/mem_access_stage.sv
// MEM stage: word-addressed data RAM with byte/half/word access, sign/zero-extended loads,
// misaligned-access squashing and a registered MEM/WB boundary.
module mem_access_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  ctr_mem,
  input  logic [1:0]  ctr_wb_in,
  input  logic [2:0]  mem_size,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  write_reg_in,
  output logic [1:0]  ctr_wb,
  output logic [31:0] mem_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  write_reg,
  output logic        misalign_err
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Picks the addressed byte/half/word out of a RAM word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  size);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = signed'(word[8*lane +: 8]);
    h = signed'(lane[1] ? word[31:16] : word[15:0]);
    case (size[1:0])
      SZ_BYTE: res = size[2] ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = size[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [1:0] lane,
                                             input logic [2:0] size);
    logic [3:0] be;
    case (size[1:0])
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicates the store operand so every enabled lane sees its own slice.
  function automatic logic [31:0] store_word(input logic [31:0] data,
                                             input logic [2:0]  size);
    logic [31:0] w;
    case (size[1:0])
      SZ_BYTE: w = {4{data[7:0]}};
      SZ_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lane,
                                         input logic [2:0] size);
    return ((size[1:0] == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

  logic [31:0]       mem_q [DEPTH];

  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              misalign;
  logic              wr_en;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;

  logic [1:0]        ctr_wb_d,    ctr_wb_q;
  logic [31:0]       mem_out_d,   mem_out_q;
  logic [31:0]       alu_out_d,   alu_out_q;
  logic [4:0]        write_reg_d, write_reg_q;
  logic              err_d,       err_q;

  assign memread  = ctr_mem[0];
  assign memwrite = ctr_mem[1];
  assign word_idx = alu_result[ADDR_W+1:2];
  assign lane     = alu_result[1:0];
  assign misalign = (memread || memwrite) && is_misaligned(lane, mem_size);
  assign wr_en    = memwrite && !misalign && !stall && !rst;
  assign be       = store_lanes(lane, mem_size);
  assign wdata    = store_word(store_data, mem_size);
  assign rd_word  = mem_q[word_idx];

  always_comb begin
    ctr_wb_d    = misalign ? 2'b00 : ctr_wb_in;
    mem_out_d   = 32'd0;
    alu_out_d   = alu_result;
    write_reg_d = write_reg_in;
    err_d       = misalign;
    // A store wins over a simultaneous read, so only a pure load drives mem_out.
    if (memread && !memwrite && !misalign) begin
      mem_out_d = load_extend(rd_word, lane, mem_size);
    end
  end

  // RAM write port: commits on the same edge that samples the store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // MEM/WB boundary register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_wb_q    <= 2'b00;
      mem_out_q   <= 32'd0;
      alu_out_q   <= 32'd0;
      write_reg_q <= 5'd0;
      err_q       <= 1'b0;
    end else if (!stall) begin
      ctr_wb_q    <= ctr_wb_d;
      mem_out_q   <= mem_out_d;
      alu_out_q   <= alu_out_d;
      write_reg_q <= write_reg_d;
      err_q       <= err_d;
    end
  end

  assign ctr_wb       = ctr_wb_q;
  assign mem_out      = mem_out_q;
  assign ALU_out      = alu_out_q;
  assign write_reg    = write_reg_q;
  assign misalign_err = err_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Sits between the EX/MEM boundary and the writeback stage.
- Performs data-memory loads and stores against an internal word-addressed RAM, with byte, halfword and word sizes and sign/zero extension.
- Registers the MEM/WB pipeline outputs (ctr_wb, mem_out, ALU_out, write_reg) on the rising edge. Writeback samples them on the following falling edge.
- Detects misaligned accesses and squashes them.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory; must be a power of two.
- ADDR_W, 8, word-index width; log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold MEM/WB register and suppress memory writes
- ctr_mem  in  2  [0]=memread, [1]=memwrite
- ctr_wb_in  in  2  [0]=memtoReg, [1]=regwrite; forwarded to writeback
- mem_size  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 word; [2]=unsigned load
- alu_result  in  32  byte address for loads/stores; ALU result otherwise
- store_data  in  32  rt value for stores
- write_reg_in  in  5  destination register
- ctr_wb  out  2  registered control to writeback
- mem_out  out  32  registered, extended load data
- ALU_out  out  32  registered alu_result
- write_reg  out  5  registered destination register
- misalign_err  out  1  registered one-cycle flag for a squashed access

Behaviour:
- Reset:
  - When rst=1 at a rising edge: ctr_wb=0, mem_out=0, ALU_out=0, write_reg=0, misalign_err=0.
  - No memory write occurs in a reset cycle. rst overrides stall.
  - RAM contents are not cleared by reset.
- Addressing:
  - Word index = alu_result[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
  - Byte lane = alu_result[1:0], little-endian (lane 0 = bits 7:0).
- Alignment:
  - Half requires alu_result[0]=0. Word requires alu_result[1:0]=00. Byte is always aligned.
  - Checked only when memread or memwrite is 1.
- Latency:
  - One cycle. Inputs are sampled at rising edge N; outputs are valid from edge N until edge N+1.
  - A store commits to RAM at edge N.
- Loads:
  - mem_out takes the selected byte/half/word from the RAM word present before edge N.
  - Sign-extended when mem_size[2]=0, zero-extended when mem_size[2]=1. Word ignores mem_size[2].
  - When memread=0, mem_out=0.
- Stores:
  - Byte writes only the addressed lane with store_data[7:0].
  - Half writes lanes {1,0} or {3,2} with store_data[15:0].
  - Word writes all lanes. Non-addressed lanes keep their values.
- Store then load, same address, consecutive cycles: the load returns the newly stored data (the write committed at the previous edge).
- memread and memwrite both 1: the store takes priority and is performed; mem_out=0; ctr_wb passes through unchanged.
- Misaligned access:
  - Store suppressed (RAM unchanged), mem_out=0, ctr_wb forced to 00 (no register write), misalign_err=1 for that cycle.
  - ALU_out and write_reg still register normally.
- Non-memory instruction (ctr_mem=00): ALU_out=alu_result, ctr_wb=ctr_wb_in, write_reg=write_reg_in, mem_out=0, misalign_err=0.
- Stall:
  - When stall=1 (and rst=0), all outputs hold their previous values, including misalign_err, and no RAM write occurs.
  - The upstream stage holds its inputs stable; the access completes on the first edge with stall=0.
- Reset mid-operation: a store present on the same edge as rst=1 is dropped. A load in flight is discarded (mem_out=0).

Test Plan:
- Reset: drive arbitrary inputs with memwrite=1 and rst=1 for 2 cycles -> all outputs 0; a later LW from the same address shows the RAM unchanged.
- Word store/load: SW 0xDEADBEEF to 0x10, then LW 0x10 next cycle -> mem_out=0xDEADBEEF, ctr_wb=11, write_reg echoes input.
- Sub-word, after word 0x10=0x8070F0AB:
  - LB 0x10 -> 0xFFFFFFAB; LBU 0x10 -> 0x000000AB.
  - LH 0x12 -> 0xFFFF8070; LHU 0x12 -> 0x00008070.
  - SB 0x13 with data 0x55, then LW -> 0x5570F0AB.
- Misaligned: SW to 0x22 -> RAM word 0x20 unchanged, misalign_err=1 for one cycle, ctr_wb=00. LH 0x11 -> mem_out=0, ctr_wb=00, misalign_err=1.
- Stall: issue SW 0x00000001 to 0x40 with stall=1 for 3 cycles -> outputs hold and RAM is unchanged; release stall -> write commits; the following LW 0x40 returns 1.
- Wrap/priority:
  - SW 0x12345678 to address 4*DEPTH+8 -> LW 0x8 returns 0x12345678.
  - memread=memwrite=1 -> store performed, mem_out=0.
